ne16_binconv_column_seq: RTL



---
 rtl/ne16_binconv_column_seq_pkg.sv | 33 +++
 rtl/ne16_binconv_column_seq_cnt.sv | 39 +++
 rtl/ne16_binconv_column_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ne16_binconv_column_seq_pkg.sv
// rtl/ne16_binconv_column_seq_pkg.sv - shared types and constants for the BinConv column sequencer
// Contents: default sizing constants, FSM state enum, config and status bundles.
package ne16_binconv_column_seq_pkg;

   localparam int NE16_COLUMN_SIZE = 9;
   localparam int NE16_QW_MAX      = 8;
   localparam int NE16_NKIN_W      = 8;
   localparam int NE16_TOTAL_W     = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } binconv_column_seq_state_t;

   typedef struct packed {
      logic [$clog2(NE16_QW_MAX):0] qw;
      logic [NE16_NKIN_W-1:0]       nkin;
      logic                         mode_1x1;
      logic [NE16_COLUMN_SIZE-1:0]  block_mask;
      logic                         pad;
   } ctrl_binconv_column_seq_t;

   typedef struct packed {
      logic                           busy;
      logic                           done;
      logic [$clog2(NE16_QW_MAX)-1:0] bit_idx;
      logic                           last;
   } flags_binconv_column_seq_t;

endpackage

// File: rtl/ne16_binconv_column_seq_cnt.sv
// rtl/ne16_binconv_column_seq_cnt.sv - nested weight-bit / input-chunk step counter
// Ports: clk, rst (sync, active-high), clr (sync zero), en (advance one step),
//        bit_max / kin_max (terminal values), bit_cnt / kin_cnt (current position),
//        bit_wrap (bit counter at terminal), kin_last (chunk counter at terminal).
module ne16_binconv_column_seq_cnt #(
   parameter int BIT_W = 3,
   parameter int KIN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [BIT_W-1:0] bit_max,
   input  logic [KIN_W-1:0] kin_max,
   output logic [BIT_W-1:0] bit_cnt,
   output logic [KIN_W-1:0] kin_cnt,
   output logic             bit_wrap,
   output logic             kin_last
);

   assign bit_wrap = (bit_cnt == bit_max);
   assign kin_last = (kin_cnt == kin_max);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         bit_cnt <= '0;
         kin_cnt <= '0;
      end else if (en) begin
         if (bit_wrap) begin
            bit_cnt <= '0;
            // Wrap the chunk counter too so a finished job leaves both at zero.
            kin_cnt <= kin_last ? '0 : kin_cnt + KIN_W'(1);
         end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ne16_binconv_column_seq.sv
// rtl/ne16_binconv_column_seq.sv - BinConv column sequencer (clear, bit-serial stepping, drain, done)
// Ports: clk_i, rst_i (sync, active-high); start_i / flush_i job control;
//        cfg_* job configuration latched on start; step_valid_i / step_ready_o weight beat;
//        pres_valid_i / pres_ready_i observed column result handshake;
//        clear_o, col_enable_o, block_enable_o, bit_idx_o, last_o column controls;
//        busy_o, done_o status.
module ne16_binconv_column_seq
   import ne16_binconv_column_seq_pkg::*;
#(
   parameter int COLUMN_SIZE     = NE16_COLUMN_SIZE,
   parameter int QW_MAX          = NE16_QW_MAX,
   parameter int NKIN_W          = NE16_NKIN_W,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic                      flush_i,
   input  logic [$clog2(QW_MAX):0]   cfg_qw_i,
   input  logic [NKIN_W-1:0]         cfg_nkin_i,
   input  logic                      cfg_mode_1x1_i,
   input  logic [COLUMN_SIZE-1:0]    cfg_block_mask_i,
   input  logic                      cfg_pad_i,
   input  logic                      step_valid_i,
   output logic                      step_ready_o,
   input  logic                      pres_valid_i,
   input  logic                      pres_ready_i,
   output logic                      clear_o,
   output logic                      col_enable_o,
   output logic [COLUMN_SIZE-1:0]    block_enable_o,
   output logic [$clog2(QW_MAX)-1:0] bit_idx_o,
   output logic                      last_o,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam int QW_W  = $clog2(QW_MAX) + 1;
   localparam int BIT_W = $clog2(QW_MAX);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int TOT_W = NE16_TOTAL_W;

   binconv_column_seq_state_t state_q, state_d;

   logic [BIT_W-1:0]       qw_m1_q;
   logic [NKIN_W-1:0]      nkin_m1_q;
   logic [TOT_W-1:0]       total_q;
   logic                   mode_1x1_q;
   logic [COLUMN_SIZE-1:0] mask_q;
   logic                   pad_q;
   logic                   flush_q;

   logic [OUT_W-1:0]       outstanding;
   logic [TOT_W-1:0]       out_cnt;

   logic [QW_W-1:0]        qw_eff;
   logic [NKIN_W-1:0]      nkin_eff;
   logic                   start_acc, flush_act, accept, res_hs, res_cnt;
   logic                   bit_wrap, kin_last, active;
   logic [BIT_W-1:0]       bit_cnt;
   logic [NKIN_W-1:0]      kin_cnt;

   // Clamp the weight-bit count into 1..QW_MAX and the chunk count to at least 1.
   always_comb begin
      qw_eff = cfg_qw_i;
      if (cfg_qw_i == '0)
         qw_eff = QW_W'(1);
      else if (cfg_qw_i > QW_W'(QW_MAX))
         qw_eff = QW_W'(QW_MAX);
   end
   assign nkin_eff = (cfg_nkin_i == '0) ? NKIN_W'(1) : cfg_nkin_i;

   assign start_acc = (state_q == ST_IDLE) && start_i;
   assign flush_act = (state_q != ST_IDLE) && flush_i;
   assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign accept    = step_valid_i && step_ready_o;
   assign res_hs    = pres_valid_i && pres_ready_i && active;
   // A result with nothing outstanding is a protocol error; it is not counted.
   assign res_cnt   = res_hs && (outstanding != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         qw_m1_q    <= '0;
         nkin_m1_q  <= '0;
         total_q    <= '0;
         mode_1x1_q <= 1'b0;
         mask_q     <= '0;
         pad_q      <= 1'b0;
      end else if (start_acc) begin
         qw_m1_q    <= BIT_W'(qw_eff - QW_W'(1));
         nkin_m1_q  <= nkin_eff - NKIN_W'(1);
         total_q    <= TOT_W'(qw_eff) * TOT_W'(nkin_eff);
         mode_1x1_q <= cfg_mode_1x1_i;
         mask_q     <= cfg_block_mask_i;
         pad_q      <= cfg_pad_i;
      end
   end

   ne16_binconv_column_seq_cnt #(
      .BIT_W (BIT_W),
      .KIN_W (NKIN_W)
   ) u_cnt (
      .clk      (clk_i),
      .rst      (rst_i),
      .clr      ((state_q == ST_CLEAR) || flush_act),
      .en       (accept),
      .bit_max  (qw_m1_q),
      .kin_max  (nkin_m1_q),
      .bit_cnt  (bit_cnt),
      .kin_cnt  (kin_cnt),
      .bit_wrap (bit_wrap),
      .kin_last (kin_last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_act || (state_q == ST_CLEAR)) begin
         outstanding <= '0;
         out_cnt     <= '0;
      end else begin
         if (accept && !res_cnt)
            outstanding <= outstanding + OUT_W'(1);
         else if (!accept && res_cnt)
            outstanding <= outstanding - OUT_W'(1);
         if (res_cnt)
            out_cnt <= out_cnt + TOT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_act;
      end
   end

   always_comb begin
      state_d        = state_q;
      step_ready_o   = 1'b0;
      clear_o        = flush_q;
      col_enable_o   = active && !pad_q;
      block_enable_o = '0;
      bit_idx_o      = bit_cnt;
      last_o         = 1'b0;
      busy_o         = (state_q != ST_IDLE);
      done_o         = 1'b0;
      if (active)
         block_enable_o = mode_1x1_q ? mask_q : {COLUMN_SIZE{1'b1}};
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            clear_o = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            step_ready_o = (outstanding < OUT_W'(MAX_OUTSTANDING));
            last_o       = bit_wrap && kin_last;
            if (accept && bit_wrap && kin_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Count the result landing this cycle so done follows the final result directly.
            if ((out_cnt + TOT_W'(res_cnt)) == total_q) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush_act) state_d = ST_IDLE;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i)
         assert (!(res_hs && (outstanding == '0)))
            else $error("column result handshake with no step outstanding");
   end
`endif

endmodule
